rr_dispatcher: RTL and testbench



---
 rtl/rr_dispatcher.sv | 136 +++++++++++++
 tb/tb_rr_dispatcher.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rr_dispatcher.sv
// Round-robin packet dispatcher: one valid/ready flit stream fanned out to N registered outputs.
// Optional per-output packet counters are built when RR_DISPATCHER_STATS_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | between packets; head flit goes to first free output from ptr
// S_LOCKED | packet in progress; every flit goes to lock until the tail
module rr_dispatcher #(
   parameter int N       = 4,
   parameter int DW      = 32,
   parameter int PRI_RST = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   in_data,
   input  logic            in_last,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [N*DW-1:0] out_data,
   output logic [N-1:0]    out_last,
   output logic [N-1:0]    out_valid,
   input  logic [N-1:0]    out_ready,
   output logic            lock_active,
   output logic [N*16-1:0] pkt_cnt
);
   localparam int            PW      = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] PTR_RST = PW'(PRI_RST);
   localparam logic [PW-1:0] PTR_MAX = PW'(N - 1);

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr, lock, target, scan_tgt, scan_idx, tgt_inc;
   logic [N-1:0]  free, wr_sel;
   logic          any_free, accept;

   assign free     = ~out_valid | out_ready;
   assign any_free = |free;
   assign accept   = in_valid & in_ready;
   assign wr_sel   = accept ? (N'(1) << target) : '0;
   assign tgt_inc  = (target == PTR_MAX) ? '0 : target + PW'(1);

   // Scan downward so the free output closest to ptr wins.
   always_comb begin
      scan_tgt = ptr;
      scan_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         scan_idx = PW'((int'(ptr) + k) % N);
         if (free[scan_idx]) scan_tgt = scan_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept && !in_last) state_nxt = S_LOCKED;
         S_LOCKED: if (accept &&  in_last) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      lock_active = 1'b0;
      target      = scan_tgt;
      in_ready    = 1'b0;
      case (state)
         S_IDLE: begin
            target   = scan_tgt;
            in_ready = any_free;
         end
         S_LOCKED: begin
            lock_active = 1'b1;
            target      = lock;
            in_ready    = free[lock];
         end
         default: ;
      endcase
      if (rst) in_ready = 1'b0;
   end

   // ptr only moves on a tail accept; lock is captured from the head flit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= PTR_RST;
         lock <= '0;
      end else if (accept) begin
         if (in_last)              ptr  <= tgt_inc;
         else if (state == S_IDLE) lock <= target;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_stage
      logic          v_q, l_q;
      logic [DW-1:0] d_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            l_q <= 1'b0;
            d_q <= '0;
         end else if (wr_sel[i]) begin
            v_q <= 1'b1;
            l_q <= in_last;
            d_q <= in_data;
         end else if (out_ready[i]) begin
            v_q <= 1'b0;
         end
      end
      assign out_valid[i]          = v_q;
      assign out_last[i]           = l_q;
      assign out_data[i*DW +: DW]  = d_q;
   end

`ifdef RR_DISPATCHER_STATS_EN
   for (genvar i = 0; i < N; i++) begin : g_cnt
      logic [15:0] cnt_q;
      always_ff @(posedge clk) begin
         if (rst)
            cnt_q <= '0;
         else if (wr_sel[i] && in_last && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
      end
      assign pkt_cnt[i*16 +: 16] = cnt_q;
   end
`else
   assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_dispatcher.sv
// Randomized bench for rr_dispatcher against a packet-level reference model.
module tb_rr_dispatcher;
   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int PRI = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   in_data = '0;
   logic            in_last = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [N*DW-1:0] out_data;
   logic [N-1:0]    out_last, out_valid;
   logic [N-1:0]    out_ready = '0;
   logic            lock_active;
   logic [N*16-1:0] pkt_cnt;

   rr_dispatcher #(.N(N), .DW(DW), .PRI_RST(PRI)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .lock_active(lock_active), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: per-output held flit, rr pointer, packet lock, tail counts
   bit          m_v[N];
   logic [DW-1:0] m_d[N];
   bit          m_l[N];
   int          m_ptr;
   bit          m_locked;
   int          m_lock;
   int          m_cnt[N];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_d[i] = '0; m_l[i] = 0; m_cnt[i] = 0;
      end
      m_ptr = PRI; m_locked = 0; m_lock = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; in_last = 1'b0; out_ready = '1;
      #1;
      chk("in_ready_in_reset", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      model_reset();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_lock_active", 64'(lock_active), 64'd0);
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
   endtask

   task automatic cycle(input bit v, input bit l, input logic [DW-1:0] d, input logic [N-1:0] rdy);
      bit fr[N];
      bit any, exp_rdy;
      int tgt;
      logic [N-1:0]    ev;
      logic [N*16-1:0] ec;
      @(negedge clk);
      in_valid = v; in_last = l; in_data = d; out_ready = rdy;
      #1;
      any = 0;
      ev  = '0;
      ec  = '0;
      for (int i = 0; i < N; i++) begin
         fr[i] = !m_v[i] || rdy[i];
         any   = any | fr[i];
         ev[i] = m_v[i];
`ifdef RR_DISPATCHER_STATS_EN
         ec[i*16 +: 16] = 16'(m_cnt[i]);
`endif
      end
      if (m_locked) begin
         tgt = m_lock;
         exp_rdy = fr[m_lock];
      end else begin
         tgt = -1;
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (tgt < 0 && fr[j]) tgt = j;
         end
         exp_rdy = any;
      end
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("lock_active", 64'(lock_active), 64'(m_locked));
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("pkt_cnt", 64'(pkt_cnt), 64'(ec));
      for (int i = 0; i < N; i++) begin
         if (m_v[i]) begin
            chk($sformatf("out_data%0d", i), 64'(out_data[i*DW +: DW]), 64'(m_d[i]));
            chk($sformatf("out_last%0d", i), 64'(out_last[i]), 64'(m_l[i]));
         end
      end
      for (int i = 0; i < N; i++)
         if (m_v[i] && rdy[i]) m_v[i] = 0;
      if (v && exp_rdy) begin
         m_v[tgt] = 1; m_d[tgt] = d; m_l[tgt] = l;
         if (l) begin
            m_ptr = (tgt + 1) % N;
            m_locked = 0;
            if (m_cnt[tgt] < 65535) m_cnt[tgt]++;
         end else begin
            m_locked = 1;
            m_lock = tgt;
         end
      end
      @(posedge clk);
   endtask

   initial begin
      model_reset();
      do_reset();

      // four single-flit packets, all outputs ready
      for (int i = 0; i < 4; i++) cycle(1, 1, 32'h100 + 32'(i), 4'hF);
      cycle(0, 0, '0, 4'hF);

      // 3-flit packet, its output stalls after the head flit
      cycle(1, 0, 32'hA, 4'hF);
      cycle(1, 0, 32'hB, 4'h0);
      cycle(1, 0, 32'hB, 4'h0);
      cycle(1, 0, 32'hB, 4'hF);
      cycle(1, 1, 32'hC, 4'hF);
      cycle(0, 0, '0, 4'hF);

      // fill every stage, stall, then release only output 3
      for (int i = 0; i < 4; i++) cycle(1, 1, 32'h200 + 32'(i), 4'h0);
      cycle(1, 1, 32'h2FF, 4'h0);
      cycle(1, 1, 32'h2FF, 4'h0);
      cycle(1, 1, 32'h300, 4'h8);
      cycle(1, 1, 32'h301, 4'h8);
      cycle(0, 0, '0, 4'hF);
      cycle(0, 0, '0, 4'hF);

      // reset in the middle of a 4-flit packet
      cycle(1, 0, 32'h400, 4'hF);
      cycle(1, 0, 32'h401, 4'hF);
      do_reset();
      cycle(1, 0, 32'h402, 4'hF);
      cycle(1, 1, 32'h403, 4'hF);
      cycle(0, 0, '0, 4'hF);

      // randomized traffic
      for (int c = 0; c < 3000; c++)
         cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3), $urandom,
               4'($urandom));

`ifdef RR_DISPATCHER_STATS_EN
      // saturate output 0 counter; outputs 1-3 fill and stall first
      cycle(0, 0, '0, 4'hF);
      cycle(0, 0, '0, 4'hF);
      for (int c = 0; c < 70000; c++) cycle(1, 1, $urandom, 4'h1);
      cycle(0, 0, '0, 4'h1);
      chk("pkt_cnt0_saturated", 64'(pkt_cnt[15:0]), 64'hFFFF);
`else
      chk("pkt_cnt_disabled", 64'(pkt_cnt), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
